// File: rtl/execute_pkg.sv
// Shared types and constants for the LEGv8 execute stage (execute_seq).
package execute_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } exec_state_e;

  localparam int N_MAX = 64;
  // Wide enough to count N iterations for any legal N (8..64).
  localparam int CNT_W = $clog2(N_MAX + 1);

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// Optional early termination when EXECUTE_MUL_EARLY_TERM_EN is defined.
module seq_mul
  import execute_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] acc_o
);

`ifdef EXECUTE_MUL_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  logic [N-1:0] b_rest;
  logic         last;
  logic         start_zero;

  assign b_rest     = b_q >> 1;
  assign last       = active_q & ((cnt_q == CNT_W'(N - 1)) | (EarlyTerm & (b_rest == '0)));
  // A zero multiplier finishes in the accept cycle itself, so active_q never rises.
  assign start_zero = start_i & EarlyTerm & (b_i == '0);
  assign done_o     = last | start_zero;
  assign acc_o      = acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      a_q      <= a_i;
      b_q      <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= !start_zero;
    end else if (active_q) begin
      if (b_q[0]) acc_q <= acc_q + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_rest;
      cnt_q <= cnt_q + 1'b1;
      if (last) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_seq.sv
// LEGv8 execute stage: single-cycle ALU, iterative multiplier and a registered
// EX/MEM output with valid/ready. Optional macro: EXECUTE_MUL_EARLY_TERM_EN.
module execute_seq
  import execute_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic         MulEn,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M,
  output logic         busy
);

  exec_state_e  state_q;
  logic         out_valid_q;
  logic [N-1:0] pcbr_q;
  logic [N-1:0] res_q;
  logic [N-1:0] wd_q;
  logic         zero_q;
  logic [N-1:0] pcbr_lat_q;
  logic [N-1:0] wd_lat_q;

  logic [N-1:0] op_b;
  logic [N-1:0] alu_d;
  logic [N-1:0] branch_d;
  logic         can_load;
  logic         accept;
  logic         mul_start;
  logic         mul_done;
  logic [N-1:0] mul_acc;

  assign op_b      = AluSrc ? signImm_E : readData2_E;
  assign branch_d  = PC_E + (signImm_E << 2);
  assign can_load  = !out_valid_q | out_ready;
  assign in_ready  = (state_q == IDLE) & can_load;
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & MulEn;
  assign busy      = (state_q == MUL);

  always_comb begin
    alu_d = '0;
    case (AluControl)
      ALU_AND:   alu_d = readData1_E & op_b;
      ALU_OR:    alu_d = readData1_E | op_b;
      ALU_ADD:   alu_d = readData1_E + op_b;
      ALU_SUB:   alu_d = readData1_E - op_b;
      ALU_PASSB: alu_d = op_b;
      ALU_NOR:   alu_d = ~(readData1_E | op_b);
      default:   alu_d = '0;
    endcase
  end

  seq_mul #(.N(N)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (mul_start),
    .a_i     (readData1_E),
    .b_i     (op_b),
    .done_o  (mul_done),
    .acc_o   (mul_acc)
  );

  // The branch target is latched as a finished sum; PC_E and signImm_E are not needed later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      pcbr_q      <= '0;
      res_q       <= '0;
      wd_q        <= '0;
      zero_q      <= 1'b0;
      pcbr_lat_q  <= '0;
      wd_lat_q    <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (MulEn) begin
              pcbr_lat_q <= branch_d;
              wd_lat_q   <= readData2_E;
              state_q    <= mul_done ? DONE : MUL;
            end else begin
              pcbr_q      <= branch_d;
              res_q       <= alu_d;
              wd_q        <= readData2_E;
              zero_q      <= (alu_d == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) state_q <= DONE;
        end
        DONE: begin
          if (can_load) begin
            pcbr_q      <= pcbr_lat_q;
            res_q       <= mul_acc;
            wd_q        <= wd_lat_q;
            zero_q      <= (mul_acc == '0);
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign PCBranch_M  = pcbr_q;
  assign aluResult_M = res_q;
  assign writeData_M = wd_q;
  assign zero_M      = zero_q;

endmodule

// File: tb/tb_execute_seq.sv
// Directed self-checking bench for execute_seq (N=64) with an expected-result queue.
module tb_execute_seq;

  localparam int N = 64;
`ifdef EXECUTE_MUL_EARLY_TERM_EN
  localparam int EXP_LAT_B4 = 4;
  localparam int EXP_LAT_B0 = 1;
`else
  localparam int EXP_LAT_B4 = 65;
  localparam int EXP_LAT_B0 = 65;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic         MulEn;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] PCBranch_M;
  logic [N-1:0] aluResult_M;
  logic [N-1:0] writeData_M;
  logic         zero_M;
  logic         busy;

  typedef struct {
    logic [N-1:0] res;
    logic [N-1:0] pcbr;
    logic [N-1:0] wd;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  execute_seq #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .MulEn       (MulEn),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .PCBranch_M  (PCBranch_M),
    .aluResult_M (aluResult_M),
    .writeData_M (writeData_M),
    .zero_M      (zero_M),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [N-1:0] alu_model(input logic [3:0] code, input logic [N-1:0] a, input logic [N-1:0] b);
    case (code)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic mul, input logic src, input logic [3:0] code,
                          input logic [N-1:0] pc, input logic [N-1:0] imm,
                          input logic [N-1:0] a, input logic [N-1:0] b2);
    exp_t e;
    logic [N-1:0] bop;
    in_valid    = 1'b1;
    MulEn       = mul;
    AluSrc      = src;
    AluControl  = code;
    PC_E        = pc;
    signImm_E   = imm;
    readData1_E = a;
    readData2_E = b2;
    bop    = src ? imm : b2;
    e.res  = mul ? a * bop : alu_model(code, a, bop);
    e.pcbr = pc + (imm << 2);
    e.wd   = b2;
    e.zero = (e.res == '0);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_empty: observed output with %0d expected entries, required >0", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, N'(out_valid), N'(1));
      check({tag, "_res"}, aluResult_M, e.res);
      check({tag, "_pcbr"}, PCBranch_M, e.pcbr);
      check({tag, "_wd"}, writeData_M, e.wd);
      check({tag, "_zero"}, N'(zero_M), N'(e.zero));
    end
  endtask

  task automatic wait_out(input int limit, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!out_valid && lat < limit) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nb;
    logic [3:0] codes [4];
    codes = '{4'b0000, 4'b0001, 4'b1100, 4'b0111};

    reset = 1'b1; in_valid = 1'b0; AluSrc = 1'b0; AluControl = '0; MulEn = 1'b0;
    PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0; out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_busy", N'(busy), N'(0));
    check("rst_res", aluResult_M, '0);
    check("rst_pcbr", PCBranch_M, '0);

    // Add with immediate: visible the cycle after accept
    drive_op(1'b0, 1'b1, 4'b0010, 64'h100, 64'd7, 64'd5, 64'h1234);
    tick();
    in_valid = 1'b0;
    check("add_res_const", aluResult_M, 64'd12);
    check("add_pcbr_const", PCBranch_M, 64'h11C);
    pop_check("add");
    tick();
    check("add_clear", N'(out_valid), N'(0));

    // Subtract to zero under back-pressure
    out_ready = 1'b0;
    drive_op(1'b0, 1'b0, 4'b0110, 64'h200, 64'h40, 64'h55, 64'h55);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sub_hold_valid", N'(out_valid), N'(1));
      check("sub_hold_zero", N'(zero_M), N'(1));
      check("sub_hold_res", aluResult_M, '0);
      check("sub_in_ready", N'(in_ready), N'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("sub_ready_release", N'(in_ready), N'(1));
    pop_check("sub");
    tick();
    check("sub_clear", N'(out_valid), N'(0));

    // Full-width multiply
    drive_op(1'b1, 1'b0, 4'b0000, 64'h300, 64'h8, 64'd3, '1);
    tick();
    in_valid = 1'b0;
    wait_out(200, lat, nb);
    check("mul_latency", N'(lat), N'(65));
    check("mul_busy_cycles", N'(nb), N'(64));
    check("mul_res_const", aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);
    pop_check("mul");
    tick();

    // Small multiplier (B=4 from immediate)
    drive_op(1'b1, 1'b1, 4'b0010, 64'h400, 64'd4, 64'd9, 64'h77);
    tick();
    in_valid = 1'b0;
    wait_out(200, lat, nb);
    check("mul_b4_latency", N'(lat), N'(EXP_LAT_B4));
    check("mul_b4_res_const", aluResult_M, 64'd36);
    pop_check("mul_b4");
    tick();

    // Zero multiplier
    drive_op(1'b1, 1'b0, 4'b0000, 64'h500, 64'h1, 64'h1234, 64'd0);
    tick();
    in_valid = 1'b0;
    wait_out(200, lat, nb);
    check("mul_b0_latency", N'(lat), N'(EXP_LAT_B0));
    pop_check("mul_b0");
    tick();

    // Reset in the middle of a multiply
    drive_op(1'b1, 1'b0, 4'b0000, 64'h600, 64'h2, 64'd3, '1);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("mid_busy_before", N'(busy), N'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("mid_rst_valid", N'(out_valid), N'(0));
    check("mid_rst_busy", N'(busy), N'(0));
    check("mid_rst_res", aluResult_M, '0);
    check("mid_rst_pcbr", PCBranch_M, '0);
    check("mid_rst_wd", writeData_M, '0);
    check("mid_rst_zero", N'(zero_M), N'(0));
    check("mid_rst_in_ready", N'(in_ready), N'(1));
    drive_op(1'b0, 1'b0, 4'b0010, 64'h700, 64'h3, 64'd100, 64'd23);
    tick();
    in_valid = 1'b0;
    pop_check("post_rst_add");
    tick();

    // Four ALU ops streamed with no bubbles
    drive_op(1'b0, 1'b0, codes[0], 64'h800, 64'h0F, 64'hF0F0, 64'h0FF0);
    tick();
    for (int i = 1; i < 4; i++) begin
      pop_check("b2b");
      drive_op(1'b0, i[0], codes[i], 64'h800 + 64'(i * 4), 64'h0F + 64'(i), 64'hF0F0 + 64'(i * 3), 64'h0FF0);
      tick();
    end
    in_valid = 1'b0;
    pop_check("b2b_last");
    tick();
    check("b2b_clear", N'(out_valid), N'(0));

    // Undefined ALU code gives zero
    drive_op(1'b0, 1'b0, 4'b0101, 64'h900, 64'h5, 64'hFF, 64'hF0);
    tick();
    in_valid = 1'b0;
    pop_check("bad_code");
    check("bad_code_zero", N'(zero_M), N'(1));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_seq.md
Name: execute_seq

Overview:
- Next-generation LEGv8 execute stage, parametrised in width N.
- Adds an iterative shift-add multiplier alongside the single-cycle ALU.
- Adds a registered EX/MEM output with a valid/ready handshake, so the stage can stall the pipeline and absorb downstream back-pressure.
- Sits between the decode/register-read stage and the memory stage; branch-target computation is carried through unchanged.

Parameters:
- N, 64, datapath width in bits (legal: 8..64, even).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  stage can accept an operation this cycle.
- AluSrc  in  1  0: operand B = readData2_E; 1: operand B = signImm_E.
- AluControl  in  4  ALU operation code.
- MulEn  in  1  1: multiply, ignoring AluControl.
- PC_E  in  N  PC of the instruction.
- signImm_E  in  N  sign-extended immediate.
- readData1_E  in  N  operand A.
- readData2_E  in  N  register operand B; also the store data.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- PCBranch_M  out  N  PC_E + (signImm_E << 2), registered.
- aluResult_M  out  N  ALU or multiply result, registered.
- writeData_M  out  N  readData2_E, registered.
- zero_M  out  1  aluResult_M == 0, registered.
- busy  out  1  multiplier iterating.

Behaviour:
- Operand B is readData2_E when AluSrc=0, else signImm_E.

ALU codes (MulEn=0):
- 0000 AND; 0001 OR; 0010 A+B; 0110 A−B; 0111 pass B; 1100 NOR.
- Any other code → result 0.
- All arithmetic is modulo 2^N; no carry or overflow outputs.

Multiply (MulEn=1):
- Unsigned A×B; the low N bits go to aluResult_M.
- Iterative: one multiplier bit per cycle, LSB first.

Handshake:
- Accept on in_valid & in_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready).
- Output transfer on out_valid & out_ready.
- All outputs are held stable while out_valid & !out_ready.
- Inputs are sampled only at accept; they are don't-care afterwards.

FSM states:
- IDLE:
  - Accept with MulEn=0 → output register loaded at that edge; out_valid=1 next cycle (latency 1); stay IDLE.
  - Accept with MulEn=1 → latch A, B, PC_E, signImm_E and readData2_E; clear the accumulator and the bit counter; go to MUL.
- MUL:
  - busy=1, in_ready=0.
  - Each cycle: if B[0], acc += A; A <<= 1; B >>= 1; count++.
  - After N iterations, go to DONE.
- DONE:
  - If !out_valid | out_ready: load the output register with acc and the latched fields; out_valid=1; go to IDLE.
  - Otherwise wait in DONE.
  - Multiply latency is N+1 cycles from accept to out_valid (65 for N=64).

Back-to-back operation:
- A simultaneous output transfer and ALU accept in the same cycle is legal; out_valid stays 1 and the new result is presented with no bubble.
- Transfer without a new accept clears out_valid.

Reset:
- Any cycle, including mid-multiply, reset forces state=IDLE.
- Reset clears out_valid, busy, zero_M, PCBranch_M, aluResult_M, writeData_M, the accumulator and the counter to 0.
- in_ready is 1 in the cycle after reset is released.
- An in-flight multiply is discarded.

Optional Feature:
- Macro EXECUTE_MUL_EARLY_TERM_EN.
- Defined: in MUL, when the remaining shifted B == 0, go to DONE in the next cycle.
  - Latency becomes (index of the highest set bit of B)+2 cycles.
  - B==0 gives latency 1, with state going directly IDLE→DONE.
- Undefined: fixed N iterations; B value has no effect on timing.

Decomposition:
- Package execute_pkg:
  - alu_op_e enum holding the six codes.
  - exec_state_e enum {IDLE, MUL, DONE}.
  - localparam for the counter width, $clog2(N+1).
- One sub-module, seq_mul:
  - Iterative multiplier with its own start/done pulses.
  - Instantiated by execute_seq.
  - Owns the accumulator, counter and early-termination logic.

Test Plan:
- ALU add, N=64: A=5, B=imm=7, AluSrc=1, AluControl=0010, PC_E=0x100 → 1 cycle later aluResult_M=12, zero_M=0, PCBranch_M=0x11C.
- Sub to zero with back-pressure: A=B=0x55, code 0110, out_ready=0 for 3 cycles → aluResult_M=0 and zero_M=1, held stable; in_ready=0 until the transfer.
- Multiply: A=3, B=0xFFFF_FFFF_FFFF_FFFF, MulEn=1 → out_valid at accept+65, aluResult_M=0xFFFF_FFFF_FFFF_FFFD; busy=1 for 64 cycles.
- Early termination (macro defined): A=9, B=4 → aluResult_M=36 at accept+4. Same stimulus without the macro → accept+65.
- Reset mid-multiply: assert reset at cycle 10 of MUL → next cycle out_valid=0, busy=0, outputs=0; a following add returns the correct result.
- Back-to-back throughput: 4 ALU ops streamed with out_ready=1 → out_valid continuously 1 for 4 cycles, results in order, no bubbles.
